// File: rtl/pong_score_fsm.sv
// Pong match controller: consumes point pulses, keeps both scores, runs the
// idle/serve/play/over match FSM and drives two active-low 7-segment digits.
module pong_score_fsm #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned PAUSE_TICKS = 25_000_000
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       point_player,
  input  logic       point_ai,
  input  logic       start,
  output logic       game_run,
  output logic       serve_dir,
  output logic [3:0] score_player,
  output logic [3:0] score_ai,
  output logic [1:0] winner,
  output logic [1:0] state,
  output logic [6:0] hex_player,
  output logic [6:0] hex_ai
);

  localparam int unsigned CntW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PAUSE_TICKS - 1);
  localparam logic [3:0] WinScore = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StServe = 2'b01,
    StPlay  = 2'b10,
    StOver  = 2'b11
  } state_e;

  state_e          state_q;
  logic            start_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      score_player_q;
  logic [3:0]      score_ai_q;
  logic [1:0]      winner_q;
  logic            game_run_q;
  logic            serve_dir_q;
  logic [6:0]      hex_player_q;
  logic [6:0]      hex_ai_q;

  logic       start_edge;
  logic [3:0] player_next;
  logic [3:0] ai_next;

  assign start_edge  = start & ~start_q;
  assign player_next = score_player_q + 4'd1;
  assign ai_next     = score_ai_q + 4'd1;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // start_q resets high so a button held through reset is not seen as a press.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      start_q        <= 1'b1;
      cnt_q          <= '0;
      score_player_q <= '0;
      score_ai_q     <= '0;
      winner_q       <= 2'b00;
      game_run_q     <= 1'b0;
      serve_dir_q    <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        StIdle: begin
          if (start_edge) begin
            state_q        <= StServe;
            score_player_q <= '0;
            score_ai_q     <= '0;
            cnt_q          <= '0;
          end
        end
        StServe: begin
          if (cnt_q == CntLast) begin
            state_q    <= StPlay;
            game_run_q <= 1'b1;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPlay: begin
          // A simultaneous pair of pulses credits only the player.
          if (point_player) begin
            score_player_q <= player_next;
            serve_dir_q    <= 1'b1;
            game_run_q     <= 1'b0;
            if (player_next == WinScore) begin
              state_q  <= StOver;
              winner_q <= 2'b01;
            end else begin
              state_q <= StServe;
              cnt_q   <= '0;
            end
          end else if (point_ai) begin
            score_ai_q  <= ai_next;
            serve_dir_q <= 1'b0;
            game_run_q  <= 1'b0;
            if (ai_next == WinScore) begin
              state_q  <= StOver;
              winner_q <= 2'b10;
            end else begin
              state_q <= StServe;
              cnt_q   <= '0;
            end
          end
        end
        StOver: begin
          if (start_edge) begin
            state_q        <= StServe;
            score_player_q <= '0;
            score_ai_q     <= '0;
            winner_q       <= 2'b00;
            cnt_q          <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_player_q <= 7'b1000000;
      hex_ai_q     <= 7'b1000000;
    end else begin
      hex_player_q <= seg7(score_player_q);
      hex_ai_q     <= seg7(score_ai_q);
    end
  end

  assign game_run     = game_run_q;
  assign serve_dir    = serve_dir_q;
  assign score_player = score_player_q;
  assign score_ai     = score_ai_q;
  assign winner       = winner_q;
  assign state        = state_q;
  assign hex_player   = hex_player_q;
  assign hex_ai       = hex_ai_q;

endmodule
